// File: rtl/tug_pull_generator.sv
// tug_pull_generator: conditions the two raw player buttons into pull requests
// for the tug-of-war light chain. Each button is passed through a 2-flop
// synchronizer and a debounce FSM. Every clean press raises a pending flag
// that is held until the next game tick (ce) samples it.
// Optional macro PULL_COUNT_EN adds saturating 8-bit press counters
// (press_cnt_l / press_cnt_r).

// One debounce FSM per player; press pulses on the edge that enters PRESSED.
module tug_pull_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // State and stability counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a level must hold for DEBOUNCE_CYCLES checks to be accepted
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RELEASED: if (level) begin
        state_nxt = PRESS_CHK;
        cnt_nxt   = '0;
      end
      PRESS_CHK: begin
        if (!level)           state_nxt = RELEASED;
        else if (cnt == LAST) state_nxt = PRESSED;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      PRESSED: if (!level) begin
        state_nxt = RELEASE_CHK;
        cnt_nxt   = '0;
      end
      RELEASE_CHK: begin
        // bouncing back high returns to PRESSED silently: no second event
        if (level)            state_nxt = PRESSED;
        else if (cnt == LAST) state_nxt = RELEASED;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      default: state_nxt = RELEASED;
    endcase
  end

  // Output: press event exactly on the transition into PRESSED
  always_comb begin
    press = (state == PRESS_CHK) && level && (cnt == LAST);
  end
endmodule

module tug_pull_generator #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       btn_l_raw,
  input  logic       btn_r_raw,
  input  logic       game_over,
  output logic       pull_l,
  output logic       pull_r
`ifdef PULL_COUNT_EN
  ,
  output logic [7:0] press_cnt_l,
  output logic [7:0] press_cnt_r
`endif
);
  // lane 0 = left player, lane 1 = right player
  logic [1:0] btn, s1, s2, press, set, pend;

  assign btn = {btn_r_raw, btn_l_raw};

  // Two-flop synchronizer per button
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  tug_pull_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
    .clk   (clk),
    .reset (reset),
    .level (s2),
    .press (press)
  );

  // game_over blocks new requests; the FSMs keep tracking regardless
  assign set = press & ~{2{game_over}};

  // Pending flags: set beats a same-edge ce clear; game_over wipes them
  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= set | (pend & ~{2{ce | game_over}});
  end

  assign pull_l = pend[0];
  assign pull_r = pend[1];

`ifdef PULL_COUNT_EN
  logic [1:0][7:0] press_cnt;

  // Count accepted sets (including merges into a pending flag), saturating
  always_ff @(posedge clk) begin
    if (reset) press_cnt <= '0;
    else
      for (int i = 0; i < 2; i++)
        if (set[i] && press_cnt[i] != 8'hff) press_cnt[i] <= press_cnt[i] + 8'd1;
  end

  assign press_cnt_l = press_cnt[0];
  assign press_cnt_r = press_cnt[1];
`endif
endmodule

// File: tb/tb_tug_pull_generator.sv
// Bench for tug_pull_generator with DEBOUNCE_CYCLES=4. Stimulus pushes the
// expected pull levels into a queue whenever it raises obs (or a ce tick);
// a negedge monitor pops and compares.
module tb_tug_pull_generator;
  logic clk = 0, reset = 1, ce = 0, btn_l_raw = 0, btn_r_raw = 0, game_over = 0;
  logic pull_l, pull_r;
  logic obs = 0;
  logic [7:0] press_cnt_l, press_cnt_r;
  int total = 0, bad = 0;

  typedef struct {
    logic       l;
    logic       r;
    logic       cc;
    logic [7:0] cl;
    logic [7:0] cr;
    string      nm;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  tug_pull_generator #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .btn_l_raw (btn_l_raw),
    .btn_r_raw (btn_r_raw),
    .game_over (game_over),
    .pull_l    (pull_l),
    .pull_r    (pull_r)
`ifdef PULL_COUNT_EN
    ,
    .press_cnt_l (press_cnt_l),
    .press_cnt_r (press_cnt_r)
`endif
  );

`ifndef PULL_COUNT_EN
  assign press_cnt_l = 8'd0;
  assign press_cnt_r = 8'd0;
`endif

  // Monitor: outputs are stable mid-cycle, exactly what the next edge sees
  always @(negedge clk) begin
    if (obs) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL no_expectation: pull_l=%0b pull_r=%0b with empty queue", pull_l, pull_r);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (pull_l !== e.l || pull_r !== e.r ||
            (e.cc && (press_cnt_l !== e.cl || press_cnt_r !== e.cr))) begin
          bad++;
          $display("FAIL %s @%0t: got l=%0b r=%0b cl=%0d cr=%0d, want l=%0b r=%0b cl=%0d cr=%0d",
                   e.nm, $time, pull_l, pull_r, press_cnt_l, press_cnt_r,
                   e.l, e.r, e.cl, e.cr);
        end
      end
    end
  end

  // One clock interval: c=ce, o=check the state left by the previous edge
  task automatic cyc(input logic c, input logic o, input logic el = 0, input logic er = 0,
                     input string nm = "", input logic cc = 0,
                     input logic [7:0] cl = 0, input logic [7:0] cr = 0);
    exp_t e;
    ce  = c;
    obs = o;
    if (o) begin
      e.l = el; e.r = er; e.cc = cc; e.cl = cl; e.cr = cr; e.nm = nm;
      q.push_back(e);
    end
    @(posedge clk); #1;
    ce  = 0;
    obs = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    cyc(0, 0);
    reset = 0;
    cyc(0, 1, 0, 0, "reset_state", 1, 0, 0);

    // Latency: pull_l rises after edge 6, not before
    btn_l_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, k >= 6, 0, "latency_l");
    btn_l_raw = 0;
    cyc(1, 1, 1, 0, "hold_until_ce");
    cyc(0, 1, 0, 0, "cleared_by_ce");
    idle(10);

    // Glitch of 3 cycles never qualifies
    btn_l_raw = 1;
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, "glitch");
    btn_l_raw = 0;
    for (int k = 0; k < 12; k++) cyc(0, 1, 0, 0, "glitch_after");

    // Completion coincides with ce: set wins, delivered at the next ce
    // (full latency here also shows the FSM fell back to RELEASED)
    btn_l_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 10; k++) cyc(k == 5 || k == 8, 1, k >= 6 && k <= 8, 0, "set_vs_ce");
    btn_l_raw = 0;
    idle(10);

    // Held right button across 10 ce ticks: one pull only
    btn_r_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 100; k++) cyc(k % 10 == 9, 1, 0, k >= 6 && k <= 9, "held_r");
    btn_r_raw = 0;
    idle(10);

    // Both players on the same cycle
    btn_l_raw = 1; btn_r_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 8; k++) cyc(0, 1, k >= 6, k >= 6, "both");
    cyc(1, 1, 1, 1, "both_hold");
    cyc(0, 1, 0, 0, "both_cleared");
    btn_l_raw = 0; btn_r_raw = 0;
    idle(10);

    // game_over during the press, then still held after it falls
    game_over = 1; btn_l_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0, "game_over_press");
    game_over = 0;
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0, "held_after_go");
    btn_l_raw = 0;
    idle(10);

    // game_over wipes an already pending pull
    btn_r_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, k >= 6, "pend_before_go");
    btn_r_raw = 0;
    game_over = 1;
    cyc(0, 1, 0, 1, "go_asserted");
    game_over = 0;
    cyc(0, 1, 0, 0, "go_cleared_pend");
    idle(10);

    // Reset in the middle of PRESS_CHK
    btn_l_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0);
    reset = 1; btn_l_raw = 0;
    cyc(0, 0);
    reset = 0;
    for (int k = 0; k < 12; k++) cyc(0, 1, 0, 0, "reset_mid_chk");

    // Reset with a pull pending
    btn_r_raw = 1;
    cyc(0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 1, 0, k >= 6, "pend_before_reset");
    btn_r_raw = 0;
    reset = 1;
    cyc(0, 1, 0, 1, "reset_asserted");
    reset = 0;
    for (int k = 0; k < 4; k++) cyc(0, 1, 0, 0, "reset_cleared_pend", 1, 0, 0);
    idle(8);

`ifdef PULL_COUNT_EN
    // 300 presses without ce: merges still count, counter saturates
    for (int p = 0; p < 300; p++) begin
      btn_l_raw = 1;
      idle(8);
      btn_l_raw = 0;
      idle(8);
      if (p == 9) cyc(0, 1, 1, 0, "count_10", 1, 8'd10, 8'd0);
    end
    cyc(0, 1, 1, 0, "count_sat", 1, 8'd255, 8'd0);
    cyc(1, 0);
    idle(2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
